jpegls_bitpack_ctrl: RTL and testbench



---
 rtl/jpegls_bitpack_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_jpegls_bitpack_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpegls_bitpack_ctrl.sv
// JPEG-LS limit-overflow bit-packing controller: packs right-aligned codewords MSB-first
// into bytes, flushes on request. Define JPEGLS_BITSTUFF_EN for post-0xFF bit stuffing.
module jpegls_bitpack_ctrl #(
  parameter int CODE_W = 32,
  parameter int LEN_W  = 6,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic [7:0]        overflow_data,
  output logic [3:0]        overflow_len,
  output logic [CNT_W-1:0]  byte_count,
  output logic              len_err
);

  localparam int BC_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_PAD   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [BC_W-1:0]    r_cnt;
  logic [CNT_W-1:0]   r_byte_count;
  logic               r_len_err;

  logic               w_ff_seen;
  logic               w_len_over;
  logic [BC_W-1:0]    w_len_clip;
  logic [BC_W-1:0]    w_need;
  logic [BC_W-1:0]    w_need_after;
  logic [BC_W-1:0]    w_cnt_acc;
  logic [BC_W-1:0]    w_cnt_drn;
  logic [ACC_W-1:0]   w_code_bits;
  logic [7:0]         w_aligned;
  logic [7:0]         w_byte;

  assign w_len_over  = ({1'b0, in_len} > (LEN_W + 1)'(CODE_W));
  assign w_len_clip  = w_len_over ? BC_W'(CODE_W) : BC_W'(in_len);
  assign w_code_bits = ACC_W'(in_code) & ~({ACC_W{1'b1}} << w_len_clip);
  assign w_need      = w_ff_seen ? BC_W'(4'd7) : BC_W'(4'd8);
  assign w_cnt_acc   = r_cnt + w_len_clip;
  assign w_cnt_drn   = r_cnt - w_need;

  // Oldest pending bits land in the low 'need' bits: right-shift when a full byte
  // is present, left-shift (zero padding) for the final partial byte.
  assign w_aligned = (r_cnt >= w_need) ? 8'(r_acc >> (r_cnt - w_need))
                                       : 8'(r_acc << (w_need - r_cnt));
  assign w_byte    = w_ff_seen ? {1'b0, w_aligned[6:0]} : w_aligned;

`ifdef JPEGLS_BITSTUFF_EN
  logic r_ff_seen;

  // Remember whether the last emitted byte was 0xFF so the next one carries a stuffed 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ff_seen <= 1'b0;
    end else if (r_state == S_DRAIN && out_ready) begin
      r_ff_seen <= (w_byte == 8'hFF);
    end else if (r_state == S_DONE) begin
      r_ff_seen <= 1'b0;
    end else begin
      r_ff_seen <= r_ff_seen;
    end
  end

  assign w_ff_seen    = r_ff_seen;
  assign w_need_after = (w_byte == 8'hFF) ? BC_W'(4'd7) : BC_W'(4'd8);
`else
  assign w_ff_seen    = 1'b0;
  assign w_need_after = BC_W'(4'd8);
`endif

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    flush_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_cnt_acc >= w_need) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (flush_req) begin
          if (r_cnt != {BC_W{1'b0}} || w_ff_seen) begin
            w_state_nxt = S_PAD;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (w_cnt_drn < w_need_after)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_PAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_PAD;
        end
      end
      S_DONE: begin
        flush_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, accumulator, bit count and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_acc        <= {ACC_W{1'b0}};
      r_cnt        <= {BC_W{1'b0}};
      r_byte_count <= {CNT_W{1'b0}};
      r_len_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc <= (r_acc << w_len_clip) | w_code_bits;
            r_cnt <= w_cnt_acc;
            if (w_len_over) begin
              r_len_err <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_cnt        <= w_cnt_drn;
            r_byte_count <= r_byte_count + CNT_W'(1'b1);
          end
        end
        S_PAD: begin
          if (out_ready) begin
            r_cnt        <= {BC_W{1'b0}};
            r_byte_count <= r_byte_count + CNT_W'(1'b1);
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign out_byte      = out_valid ? w_byte : 8'h00;
  assign overflow_data = 8'(r_acc & ~({ACC_W{1'b1}} << r_cnt));
  assign overflow_len  = (r_cnt > BC_W'(4'd8)) ? 4'd8 : r_cnt[3:0];
  assign byte_count    = r_byte_count;
  assign len_err       = r_len_err;

endmodule

// File: tb/tb_jpegls_bitpack_ctrl.sv
// Self-checking bench for jpegls_bitpack_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a bit-queue reference model.
module tb_jpegls_bitpack_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_code;
  logic [5:0]  in_len;
  logic        flush_req;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic [7:0]  overflow_data;
  logic [3:0]  overflow_len;
  logic [15:0] byte_count;
  logic        len_err;

  jpegls_bitpack_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_len(in_len), .flush_req(flush_req), .flush_done(flush_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .overflow_data(overflow_data), .overflow_len(overflow_len),
    .byte_count(byte_count), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] got_q[$];
  bit rnd_ready = 1'b0;

  // reference model: pending bits as a queue, expected bytes as a queue
  bit         mq[$];
  bit         m_ff;
  logic [7:0] exp_q[$];
  int         exp_total;

  typedef struct {
    logic [31:0] code_a;
    logic [5:0]  len_a;
    logic [31:0] code_b;
    logic [5:0]  len_b;
    int          nbytes;
    logic [31:0] bytes;
    logic [3:0]  ovl_len;
    logic [7:0]  ovl_data;
  } vec_t;

  vec_t tbl[6];

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back(out_byte);
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_emit();
    logic [7:0] b;
    int need;
    need = m_ff ? 7 : 8;
    while (mq.size() >= need) begin
      b = 8'h00;
      for (int k = 0; k < need; k++) b = {b[6:0], mq.pop_front()};
      exp_q.push_back(b);
      exp_total++;
`ifdef JPEGLS_BITSTUFF_EN
      m_ff = (b == 8'hFF);
`endif
      need = m_ff ? 7 : 8;
    end
  endfunction

  function automatic void m_push(input logic [31:0] code, input int len);
    int l;
    l = (len > 32) ? 32 : len;
    for (int i = l - 1; i >= 0; i--) mq.push_back(code[i]);
    m_emit();
  endfunction

  function automatic void m_flush();
    logic [7:0] b;
    int need;
    need = m_ff ? 7 : 8;
    if (mq.size() > 0 || m_ff) begin
      b = 8'h00;
      for (int k = 0; k < need; k++) b = {b[6:0], (mq.size() > 0) ? mq.pop_front() : 1'b0};
      exp_q.push_back(b);
      exp_total++;
    end
    m_ff = 1'b0;
    mq.delete();
  endfunction

  function automatic logic [7:0] m_resid();
    logic [7:0] v;
    v = 8'h00;
    foreach (mq[i]) v = {v[6:0], mq[i]};
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush_req = 1'b0; out_ready = 1'b0;
    in_code = 32'h0; in_len = 6'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    got_q.delete();
  endtask

  // present one codeword and hold it until accepted (starts/ends 1 time unit after posedge)
  task automatic send(input logic [31:0] c, input logic [5:0] l);
    bit ok;
    ok = 1'b0;
    in_code = c; in_len = l; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // wait (at negedge) until the controller is idle again
  task automatic settle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("settle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_flush(output bit seen);
    seen = 1'b0;
    flush_req = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (flush_done) begin seen = 1'b1; break; end
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk);
    #1 flush_req = 1'b0;
  endtask

  initial begin
    bit seen;
    logic [31:0] code;
    int len;
    bit exp_lerr;
    logic [7:0] bp[4];

    tbl[0] = '{32'h5, 6'd3, 32'h13, 6'd5, 1, 32'hB3000000, 4'd0, 8'h00};
`ifdef JPEGLS_BITSTUFF_EN
    tbl[1] = '{32'hFF80, 6'd16, 32'h0, 6'd0, 2, 32'hFF400000, 4'd1, 8'h00};
    tbl[5] = '{32'hFFFFF1FF, 6'd9, 32'h55, 6'd7, 2, 32'hFF6A0000, 4'd1, 8'h01};
`else
    tbl[1] = '{32'hFF80, 6'd16, 32'h0, 6'd0, 2, 32'hFF800000, 4'd0, 8'h00};
    tbl[5] = '{32'hFFFFF1FF, 6'd9, 32'h55, 6'd7, 2, 32'hFFD50000, 4'd0, 8'h00};
`endif
    tbl[2] = '{32'h6, 6'd3, 32'h0, 6'd0, 0, 32'h0, 4'd3, 8'h06};
    tbl[3] = '{32'hDEADBEEF, 6'd32, 32'h0, 6'd0, 4, 32'hDEADBEEF, 4'd0, 8'h00};
    tbl[4] = '{32'hABC, 6'd12, 32'h5, 6'd4, 2, 32'hABC50000, 4'd0, 8'h00};

    // reset values
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_ovl_len", overflow_len, 0);
    chk("rst_ovl_data", overflow_data, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_flush_done", flush_done, 0);
    @(posedge clk); #1;

    // vector table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      out_ready = 1'b1;
      send(tbl[i].code_a, tbl[i].len_a);
      send(tbl[i].code_b, tbl[i].len_b);
      settle();
      chk($sformatf("vec%0d_nbytes", i), got_q.size(), tbl[i].nbytes);
      for (int k = 0; k < tbl[i].nbytes && k < got_q.size(); k++)
        chk($sformatf("vec%0d_byte%0d", i, k), got_q[k], tbl[i].bytes[31-8*k -: 8]);
      chk($sformatf("vec%0d_ovl_len", i), overflow_len, tbl[i].ovl_len);
      chk($sformatf("vec%0d_ovl_data", i), overflow_data, tbl[i].ovl_data);
      chk($sformatf("vec%0d_byte_count", i), byte_count, tbl[i].nbytes);
      @(posedge clk); #1;
    end

    // flush with 3 residual bits, then flush with nothing pending
    do_reset();
    out_ready = 1'b1;
    send(32'h6, 6'd3);
    do_flush(seen);
    chk("flush_seen", seen, 1);
    @(negedge clk);
    chk("flush_single_pulse", flush_done, 0);
    chk("flush_nbytes", got_q.size(), 1);
    if (got_q.size() > 0) chk("flush_pad_byte", got_q[0], 8'hC0);
    chk("flush_ovl_len", overflow_len, 0);
    chk("flush_byte_count", byte_count, 1);
    @(posedge clk); #1;
    got_q.delete();
    do_flush(seen);
    chk("flush_empty_seen", seen, 1);
    @(negedge clk);
    chk("flush_empty_nbytes", got_q.size(), 0);
    chk("flush_empty_byte_count", byte_count, 1);
    @(posedge clk); #1;

    // backpressure on a 32-bit code
    do_reset();
    out_ready = 1'b0;
    send(32'hDEADBEEF, 6'd32);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("bp_hold", {in_ready, out_valid, out_byte}, {1'b0, 1'b1, 8'hDE});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    bp[0] = 8'hDE; bp[1] = 8'hAD; bp[2] = 8'hBE; bp[3] = 8'hEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp_stream%0d", k), {out_valid, out_byte}, {1'b1, bp[k]});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_back_idle", {in_ready, out_valid}, {1'b1, 1'b0});
    @(posedge clk); #1;

    // zero-length code, then oversize length
    do_reset();
    out_ready = 1'b1;
    send(32'h6, 6'd3);
    send(32'hFFFFFFFF, 6'd0);
    settle();
    chk("len0_nbytes", got_q.size(), 0);
    chk("len0_ovl_len", overflow_len, 3);
    chk("len0_ovl_data", overflow_data, 8'h06);
    chk("len0_len_err", len_err, 0);
    @(posedge clk); #1;
    do_reset();
    out_ready = 1'b1;
    send(32'h12345678, 6'd40);
    settle();
    chk("len40_len_err", len_err, 1);
    chk("len40_nbytes", got_q.size(), 4);
    if (got_q.size() == 4) chk("len40_bytes", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'h12345678);
    @(posedge clk); #1;
    send(32'h5, 6'd3);
    settle();
    chk("len40_sticky", len_err, 1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("len40_cleared", len_err, 0);
    @(posedge clk); #1;

    // reset in the middle of a drain
    out_ready = 1'b0;
    send(32'hABCDEF, 6'd24);
    @(negedge clk);
    chk("rstdrain_pre_valid", out_valid, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstdrain_state", {out_valid, in_ready, flush_done, overflow_len}, {1'b0, 1'b1, 1'b0, 4'd0});
    chk("rstdrain_byte_count", byte_count, 0);
    @(posedge clk); #1;

    // randomized traffic against the bit-queue model
    do_reset();
    mq.delete(); exp_q.delete(); m_ff = 1'b0; exp_total = 0; exp_lerr = 1'b0;
    rnd_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      code = $urandom;
      len = ($urandom_range(0, 15) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
      if (len > 32) exp_lerr = 1'b1;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(code, 6'(len));
      m_push(code, len);
      if ($urandom_range(0, 19) == 0) begin
        m_flush();
        do_flush(seen);
        chk("rand_flush_seen", seen, 1);
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    settle();
    chk("rand_nbytes", got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk($sformatf("rand_byte%0d", k), got_q[k], exp_q[k]);
    chk("rand_ovl_len", overflow_len, mq.size());
    chk("rand_ovl_data", overflow_data, m_resid());
    chk("rand_len_err", len_err, exp_lerr);
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
    m_flush();
    do_flush(seen);
    chk("rand_final_flush_seen", seen, 1);
    @(negedge clk);
    chk("rand_final_nbytes", got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk($sformatf("rand_final_byte%0d", k), got_q[k], exp_q[k]);
    chk("rand_final_ovl_len", overflow_len, 0);
    chk("rand_byte_count", byte_count, 16'(exp_total));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
